// File: rtl/snn_out_pkg.sv
// Shared types and sizing helpers for the spike output classifier.
package snn_out_pkg;

    localparam int DEF_NUM_OUTPUT = 250;
    localparam int DEF_NUM_CLASS  = 10;
    localparam int DEF_IDX_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        ARGMAX,
        HOLD
    } state_t;

    // The widest class receives ceil(num_output/num_class) votes, so the counter must hold that value.
    function automatic int cnt_width(input int num_output, input int num_class);
        return $clog2((num_output + num_class - 1) / num_class + 1);
    endfunction

endpackage

// File: rtl/spike_vote_counter.sv
// Per-class vote accumulation fed one bitmap bit per cycle, followed by a serial argmax scan.
module spike_vote_counter
    import snn_out_pkg::*;
#(
    parameter int NUM_CLASS = DEF_NUM_CLASS,
    parameter int CNT_W     = cnt_width(DEF_NUM_OUTPUT, DEF_NUM_CLASS),
    parameter int CLS_W     = $clog2(NUM_CLASS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             count_en,
    input  logic             spike_bit,
    input  logic             argmax_en,
    input  logic             rewind,
    output logic [CLS_W-1:0] best_class,
    output logic [CNT_W-1:0] best_votes
);

    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASS - 1);

    logic [CNT_W-1:0] votes [NUM_CLASS];
    logic [CLS_W-1:0] cls_idx;
    logic [CLS_W-1:0] cls_wrap;

    // Wrapping modulo counter tracks neuron index mod NUM_CLASS without a divider.
    assign cls_wrap = (cls_idx == CLS_LAST) ? '0 : cls_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cls_idx    <= '0;
            best_class <= '0;
            best_votes <= '0;
            // NOTE: the vote array is only a handful of registers and must start every frame at zero, so it is cleared explicitly rather than left as uninitialised storage.
            for (int c = 0; c < NUM_CLASS; c++) begin
                votes[c] <= '0;
            end
        end else begin
            if (count_en && spike_bit) begin
                votes[cls_idx] <= votes[cls_idx] + 1'b1;
            end
            // Strictly-greater replacement keeps the lowest class on ties.
            if (argmax_en && (votes[cls_idx] > best_votes)) begin
                best_class <= cls_idx;
                best_votes <= votes[cls_idx];
            end
            if (rewind) begin
                cls_idx <= '0;
            end else if (count_en || argmax_en) begin
                cls_idx <= cls_wrap;
            end
        end
    end

endmodule

// File: rtl/spike_frame_classifier.sv
// Collects output spikes into a per-tick bitmap, votes per class, and hands the frame plus argmax class to the host over valid/ready.
module spike_frame_classifier
    import snn_out_pkg::*;
#(
    parameter int NUM_OUTPUT = DEF_NUM_OUTPUT,
    parameter int NUM_CLASS  = DEF_NUM_CLASS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int SKIP_FIRST = 1,
    parameter int CNT_W      = cnt_width(NUM_OUTPUT, NUM_CLASS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         packet_out_valid,
    input  logic [IDX_W-1:0]             packet_out,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [NUM_OUTPUT-1:0]        frame_data,
    output logic [$clog2(NUM_CLASS)-1:0] class_id,
    output logic [CNT_W-1:0]             max_votes,
    output logic                         busy,
    output logic                         range_err,
    output logic                         overflow_err,
    output logic [15:0]                  dropped_cnt
);

    localparam int CLS_W     = $clog2(NUM_CLASS);
    localparam int STEP_W    = $clog2(NUM_OUTPUT);
    localparam int IDX_LIM_W = IDX_W + 1;

    localparam logic [STEP_W-1:0]    COUNT_LAST  = STEP_W'(NUM_OUTPUT - 1);
    localparam logic [STEP_W-1:0]    ARGMAX_LAST = STEP_W'(NUM_CLASS - 1);
    localparam logic [IDX_LIM_W-1:0] IDX_LIMIT   = IDX_LIM_W'(NUM_OUTPUT);

    state_t                state;
    state_t                state_next;
    logic [STEP_W-1:0]     step;
    logic [NUM_OUTPUT-1:0] acc;
    logic [NUM_OUTPUT-1:0] spike_vec;
    logic                  first_pending;
    logic                  in_range;
    logic                  tick_live;
    logic                  latch;
    logic                  count_en;
    logic                  argmax_en;
    logic                  rewind;
    logic                  drop;

    assign in_range  = {1'b0, packet_out} < IDX_LIMIT;
    assign tick_live = tick && !first_pending;

    always_comb begin
        spike_vec = '0;
        if (packet_out_valid && in_range) begin
            spike_vec[COUNT_LAST - STEP_W'(packet_out)] = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a value held and infer a latch.
        state_next = state;
        latch      = 1'b0;
        count_en   = 1'b0;
        argmax_en  = 1'b0;
        rewind     = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick_live) begin
                    latch      = 1'b1;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                count_en = 1'b1;
                drop     = tick_live;
                if (step == COUNT_LAST) begin
                    rewind     = 1'b1;
                    state_next = ARGMAX;
                end
            end
            ARGMAX: begin
                argmax_en = 1'b1;
                drop      = tick_live;
                if (step == ARGMAX_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    // A tick coinciding with the handshake starts the next frame without a drop.
                    latch      = tick_live;
                    state_next = tick_live ? COUNT : IDLE;
                end else begin
                    drop = tick_live;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            step          <= '0;
            acc           <= '0;
            frame_data    <= '0;
            first_pending <= (SKIP_FIRST != 0);
            range_err     <= 1'b0;
            overflow_err  <= 1'b0;
            dropped_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
            state <= state_next;
            if (latch || (state_next != state)) begin
                step <= '0;
            end else if ((state == COUNT) || (state == ARGMAX)) begin
                step <= step + 1'b1;
            end
            // A spike in the tick cycle belongs to the closing frame, then the accumulator restarts empty.
            acc <= tick ? '0 : (acc | spike_vec);
            if (latch) begin
                frame_data <= acc | spike_vec;
            end
            if (tick) begin
                first_pending <= 1'b0;
            end
            if (packet_out_valid && !in_range) begin
                range_err <= 1'b1;
            end
            if (drop) begin
                overflow_err <= 1'b1;
                if (dropped_cnt != 16'hFFFF) begin
                    dropped_cnt <= dropped_cnt + 1'b1;
                end
            end
        end
    end

    spike_vote_counter #(
        .NUM_CLASS (NUM_CLASS),
        .CNT_W     (CNT_W),
        .CLS_W     (CLS_W)
    ) u_vote (
        .clk        (clk),
        .reset      (reset),
        .clear      (latch),
        .count_en   (count_en),
        .spike_bit  (frame_data[COUNT_LAST - step]),
        .argmax_en  (argmax_en),
        .rewind     (rewind),
        .best_class (class_id),
        .best_votes (max_votes)
    );

    assign frame_valid = (state == HOLD);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spike_frame_classifier.sv
// Directed bench for spike_frame_classifier at default parameters with hand-computed frames and classes.
module tb_spike_frame_classifier;

    localparam int NO  = 250;
    localparam int NC  = 10;
    localparam int LAT = NO + NC;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          packet_out_valid;
    logic [7:0]    packet_out;
    logic          frame_valid;
    logic          frame_ready;
    logic [NO-1:0] frame_data;
    logic [3:0]    class_id;
    logic [4:0]    max_votes;
    logic          busy;
    logic          range_err;
    logic          overflow_err;
    logic [15:0]   dropped_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_frame_classifier dut (
        .clk              (clk),
        .reset            (reset),
        .tick             (tick),
        .packet_out_valid (packet_out_valid),
        .packet_out       (packet_out),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .frame_data       (frame_data),
        .class_id         (class_id),
        .max_votes        (max_votes),
        .busy             (busy),
        .range_err        (range_err),
        .overflow_err     (overflow_err),
        .dropped_cnt      (dropped_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NO-1:0] bit_of(input int idx);
        logic [NO-1:0] v;
        v = '0;
        v[NO-1-idx] = 1'b1;
        return v;
    endfunction

    task automatic send_spike(input int idx);
        packet_out_valid = 1'b1;
        packet_out       = 8'(idx);
        cycle();
        packet_out_valid = 1'b0;
    endtask

    task automatic send_tick(input logic with_spike, input int idx, input logic ready);
        tick             = 1'b1;
        packet_out_valid = with_spike;
        packet_out       = 8'(idx);
        frame_ready      = ready;
        cycle();
        tick             = 1'b0;
        packet_out_valid = 1'b0;
        frame_ready      = 1'b0;
    endtask

    // Counts clock edges after the tick edge until frame_valid; bounded so a dead DUT still reaches the summary.
    task automatic wait_frame(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (frame_valid !== 1'b1 && n < LAT + 50) begin
            cycle();
            n++;
        end
        check({tag, "_latency"}, 256'(n), 256'(exp_lat));
    endtask

    task automatic expect_frame(input string tag, input logic [NO-1:0] bits, input int cls, input int votes);
        check({tag, "_valid"}, 256'(frame_valid), 256'(1));
        check({tag, "_data"}, 256'(frame_data), 256'(bits));
        check({tag, "_class"}, 256'(class_id), 256'(cls));
        check({tag, "_votes"}, 256'(max_votes), 256'(votes));
    endtask

    task automatic consume(input string tag);
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        check({tag, "_valid_drop"}, 256'(frame_valid), 256'(0));
        check({tag, "_idle"}, 256'(busy), 256'(0));
    endtask

    task automatic no_frame(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            cycle();
            if (frame_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, 256'(seen), 256'(0));
    endtask

    initial begin
        reset            = 1'b1;
        tick             = 1'b0;
        packet_out_valid = 1'b0;
        packet_out       = '0;
        frame_ready      = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        check("rst_valid", 256'(frame_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_data", 256'(frame_data), 256'(0));
        check("rst_class", 256'(class_id), 256'(0));
        check("rst_votes", 256'(max_votes), 256'(0));
        check("rst_errs", 256'({range_err, overflow_err}), 256'(0));
        check("rst_dropped", 256'(dropped_cnt), 256'(0));

        // First tick after reset only clears the accumulator.
        send_spike(3);
        send_tick(1'b0, 0, 1'b0);
        check("skip_busy", 256'(busy), 256'(0));
        no_frame("skip_no_frame", LAT + 20);

        // Duplicate 20 counts once: class 0 = {0,10,20}, class 5 = {5}; bit 246 (idx 3) must be gone.
        send_spike(0);
        send_spike(10);
        send_spike(20);
        send_spike(20);
        send_spike(5);
        send_tick(1'b0, 0, 1'b0);
        wait_frame("f1", LAT);
        expect_frame("f1", bit_of(0) | bit_of(10) | bit_of(20) | bit_of(5), 0, 3);
        repeat (3) cycle();
        expect_frame("f1_hold", bit_of(0) | bit_of(10) | bit_of(20) | bit_of(5), 0, 3);
        consume("f1");

        // Tie between class 2 and 7 resolves to the lower class.
        send_spike(2);
        send_spike(7);
        send_tick(1'b0, 0, 1'b0);
        wait_frame("tie", LAT);
        expect_frame("tie", bit_of(2) | bit_of(7), 2, 1);
        consume("tie");

        check("range_clear", 256'(range_err), 256'(0));
        send_spike(250);
        check("range_set", 256'(range_err), 256'(1));
        send_tick(1'b0, 0, 1'b0);
        wait_frame("zero", LAT);
        expect_frame("zero", '0, 0, 0);
        consume("zero");

        // Tick in HOLD without ready drops the new frame and leaves the held one intact.
        send_spike(1);
        send_spike(11);
        send_tick(1'b0, 0, 1'b0);
        wait_frame("ovf", LAT);
        expect_frame("ovf", bit_of(1) | bit_of(11), 1, 2);
        send_spike(4);
        send_tick(1'b0, 0, 1'b0);
        check("ovf_flag", 256'(overflow_err), 256'(1));
        check("ovf_dropped", 256'(dropped_cnt), 256'(1));
        expect_frame("ovf_kept", bit_of(1) | bit_of(11), 1, 2);
        // Tick plus ready in HOLD: handshake and new frame in one cycle; spike 4 was cleared by the drop.
        send_tick(1'b1, 6, 1'b1);
        check("hs_valid", 256'(frame_valid), 256'(0));
        check("hs_busy", 256'(busy), 256'(1));
        wait_frame("hs", LAT);
        expect_frame("hs", bit_of(6), 6, 1);
        check("hs_dropped", 256'(dropped_cnt), 256'(1));
        consume("hs");

        // Spike in the tick cycle joins the closing frame; a tick mid-COUNT is dropped.
        send_tick(1'b1, 9, 1'b0);
        repeat (5) cycle();
        send_tick(1'b0, 0, 1'b0);
        check("cnt_drop", 256'(dropped_cnt), 256'(2));
        wait_frame("s9", LAT - 6);
        expect_frame("s9", bit_of(9), 9, 1);
        consume("s9");

        // Reset mid-COUNT abandons the frame and re-arms the first-tick skip.
        send_tick(1'b1, 9, 1'b0);
        repeat (20) cycle();
        check("mid_busy", 256'(busy), 256'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mr_busy", 256'(busy), 256'(0));
        check("mr_valid", 256'(frame_valid), 256'(0));
        check("mr_errs", 256'({range_err, overflow_err}), 256'(0));
        check("mr_dropped", 256'(dropped_cnt), 256'(0));
        no_frame("mr_no_frame", LAT + 20);
        send_spike(3);
        send_tick(1'b0, 0, 1'b0);
        check("mr_skip_busy", 256'(busy), 256'(0));
        no_frame("mr_skip", LAT + 20);
        send_spike(8);
        send_tick(1'b0, 0, 1'b0);
        wait_frame("post", LAT);
        expect_frame("post", bit_of(8), 8, 1);
        consume("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_frame_classifier.md
Name: spike_frame_classifier

Overview:
- Sits directly downstream of the RANC network grid output port.
- Collects output spike packets (8-bit neuron index with valid) into a per-tick spike bitmap.
- On each tick, snapshots the bitmap and counts votes per class serially. Class mapping is neuron index mod NUM_CLASS.
- Selects the argmax class, then presents the frame and the class result on a valid/ready interface to the host/SoC side.

Parameters:
NUM_OUTPUT, 250, number of output neurons (bitmap width)
NUM_CLASS, 10, number of classes; neuron n votes for class n mod NUM_CLASS
IDX_W, 8, width of incoming spike index
SKIP_FIRST, 1, when 1 the first tick after reset only clears the accumulator and emits no frame
CNT_W, $clog2(NUM_OUTPUT/NUM_CLASS+1), derived width of vote counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle tick pulse closing the current frame
packet_out_valid  in  1  spike valid from network grid
packet_out  in  IDX_W  spiking neuron index
frame_valid  out  1  result frame available
frame_ready  in  1  consumer accepts frame
frame_data  out  NUM_OUTPUT  spike bitmap; neuron n maps to bit NUM_OUTPUT-1-n
class_id  out  $clog2(NUM_CLASS)  winning class
max_votes  out  CNT_W  vote count of winning class
busy  out  1  FSM not in IDLE
range_err  out  1  sticky: index >= NUM_OUTPUT received
overflow_err  out  1  sticky: tick arrived while previous frame unfinished/unconsumed
dropped_cnt  out  16  saturating count of dropped frames

Behaviour:
- Reset: all outputs 0, accumulator 0, FSM IDLE, first-tick flag armed.
- Accumulate:
  - packet_out_valid with idx < NUM_OUTPUT sets acc[NUM_OUTPUT-1-idx]. Duplicates are idempotent.
  - idx >= NUM_OUTPUT is ignored and sets range_err.
- Tick:
  - A spike in the same cycle as tick belongs to the closing frame.
  - Snapshot = acc | that spike. acc is 0 on the following cycle.
  - First tick after reset with SKIP_FIRST=1: clear only, no frame. The flag then disarms.
- FSM IDLE -> COUNT -> ARGMAX -> HOLD -> IDLE.
  - IDLE: on tick (not skipped), latch snapshot into frame_data, zero vote counters, go to COUNT.
  - COUNT: exactly NUM_OUTPUT cycles, neuron n = 0..NUM_OUTPUT-1.
    - If the bit is set, votes[n mod NUM_CLASS]++.
    - Class index comes from a wrapping modulo counter; no divider.
  - ARGMAX: exactly NUM_CLASS cycles, classes 0..NUM_CLASS-1.
    - A class replaces the best only if strictly greater, so ties resolve to the lowest class.
    - Initial best is class 0 with 0 votes.
  - HOLD: frame_valid=1, with frame_data, class_id and max_votes stable until frame_ready. On handshake, frame_valid falls the next cycle and the FSM returns to IDLE.
- Latency: tick at cycle T gives frame_valid=1 at T+1+NUM_OUTPUT+NUM_CLASS (T+261 at defaults).
- Tick while in COUNT/ARGMAX, or in HOLD without frame_ready:
  - The new frame is dropped and acc is still cleared.
  - overflow_err is set and dropped_cnt increments, saturating at 0xFFFF.
  - Outputs are unchanged.
- Tick in HOLD with frame_ready in the same cycle: the handshake completes, the new snapshot is latched and the FSM goes directly to COUNT. No drop.
- All-zero frame: class_id=0, max_votes=0; the frame is still emitted.
- Reset mid-operation: immediate return to reset state. No partial frame is emitted, and the first-tick skip is re-armed.
- Vote counters cannot overflow: CNT_W covers ceil(NUM_OUTPUT/NUM_CLASS).

Decomposition:
- Package snn_out_pkg holds:
  - the FSM state enum (IDLE, COUNT, ARGMAX, HOLD);
  - defaults for NUM_OUTPUT, NUM_CLASS and IDX_W;
  - the CNT_W helper function.
- Sub-module spike_vote_counter: vote counter array, modulo class counter and serial argmax. The top module keeps the accumulator, FSM, handshake and error logic.

Test Plan:
- Reset; spike idx 3; tick -> no frame_valid (first tick skipped); acc cleared, so bit 246 is absent from the next frame.
- Spikes idx 0,10,20,20,5; tick at T:
  - frame_valid at T+261;
  - frame_data bits 249,239,229,244 set, others 0;
  - class_id=0, max_votes=3 (duplicate 20 counted once).
- Spikes idx 2 and 7; tick -> class_id=2, max_votes=1 (tie resolves to lowest class).
- Spike idx 250; tick -> range_err=1; frame all zero; class_id=0, max_votes=0.
- Hold frame_ready=0 after a frame is valid; apply a second tick:
  - overflow_err=1, dropped_cnt=1;
  - frame_data unchanged;
  - tick with frame_ready=1 in HOLD -> new frame follows with no drop.
- Spike idx 9 in the tick cycle -> frame bit 240 set, class_id=9. Then assert reset mid-COUNT -> frame_valid stays 0, busy=0, and the next tick is skipped.
